// File: rtl/tinyqv_peri_fabric.sv
// TinyQV peripheral fabric: address decode to one-hot slot selects, held read
// data with a not-ready timeout, slot 1 control registers (GPIO, interrupts,
// status, pin function select) and registered GPIO pad outputs.
module tinyqv_peri_fabric #(
    parameter int          NUM_USER       = 16,
    parameter int          NUM_SIMPLE     = 16,
    parameter int          NUM_GPIO       = 8,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] TIMEOUT_DATA   = 32'hFFFF_FFFF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [10:0]             addr_in,
    input  logic [31:0]             data_in,
    input  logic [1:0]              data_write_n,
    input  logic [1:0]              data_read_n,
    input  logic                    data_read_complete,
    output logic [31:0]             data_out,
    output logic                    data_ready,
    output logic [NUM_USER-1:0]     user_sel,
    output logic [NUM_SIMPLE-1:0]   simple_sel,
    input  logic [32*NUM_USER-1:0]  user_data,
    input  logic [NUM_USER-1:0]     user_ready,
    input  logic [NUM_USER-1:0]     user_irq,
    input  logic [8*NUM_SIMPLE-1:0] simple_data,
    input  logic [8*NUM_USER-1:0]   user_uo,
    input  logic [8*NUM_SIMPLE-1:0] simple_uo,
    input  logic [NUM_GPIO-1:0]     ui_in,
    output logic [NUM_GPIO-1:0]     uo_out,
    output logic [NUM_USER-1:0]     irq_out
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    // Slots 0 and 1 never raise interrupts (reserved / this block)
    localparam logic [NUM_USER-1:0] IRQ_MASK = {{(NUM_USER-2){1'b1}}, 2'b00};

    // Decode
    logic       read_req;
    logic       write_req;
    logic       ctrl_sel;
    logic       ctrl_wr;
    logic [5:0] reg_off;

    assign read_req  = (data_read_n != 2'b11);
    assign write_req = (data_write_n != 2'b11);
    assign ctrl_sel  = !addr_in[10] && (addr_in[9:6] == 4'd1);
    assign ctrl_wr   = write_req && ctrl_sel;
    assign reg_off   = addr_in[5:0];

    // State
    logic [31:0]         data_out_reg;
    logic                hold_reg;
    logic [CNT_W-1:0]    wait_cnt_reg;
    logic                timeout_flag_reg;
    logic [NUM_GPIO-1:0] gpio_out_reg;
    logic [NUM_USER-1:0] irq_prev_reg;
    logic [NUM_USER-1:0] irq_pending_reg;
    logic [NUM_USER-1:0] irq_enable_reg;
    logic [NUM_GPIO-1:0] uo_out_reg;
    logic [4:0]          func_sel [NUM_GPIO];
    logic [NUM_GPIO-1:0] pin_next;

    // Unpacked views of the flattened peripheral buses
    logic [31:0] user_data_arr   [NUM_USER];
    logic [7:0]  user_uo_arr     [NUM_USER];
    logic [7:0]  simple_data_arr [NUM_SIMPLE];
    logic [7:0]  simple_uo_arr   [NUM_SIMPLE];

    generate
        for (genvar gi = 0; gi < NUM_USER; gi++) begin : g_user
            assign user_sel[gi]      = !addr_in[10] && (addr_in[9:6] == 4'(gi));
            assign user_data_arr[gi] = user_data[32*gi +: 32];
            assign user_uo_arr[gi]   = user_uo[8*gi +: 8];
        end
        for (genvar gi = 0; gi < NUM_SIMPLE; gi++) begin : g_simple
            assign simple_sel[gi]      = addr_in[10] && (addr_in[7:4] == 4'(gi));
            assign simple_data_arr[gi] = simple_data[8*gi +: 8];
            assign simple_uo_arr[gi]   = simple_uo[8*gi +: 8];
        end
    endgenerate

    // Slot 0/1 data and ready inputs are replaced internally; upper write bits have no target
    logic unused_inputs;
    assign unused_inputs = ^{data_in[31:16], user_data[63:0], user_ready[1:0], user_uo[15:8]};

    // Control register read mux
    logic [31:0] ctrl_rdata;
    always_comb begin
        ctrl_rdata = 32'h0;
        case (reg_off)
            6'h00:   ctrl_rdata = 32'(gpio_out_reg);
            6'h04:   ctrl_rdata = 32'(ui_in);
            6'h08:   ctrl_rdata = 32'(irq_pending_reg);
            6'h0C:   ctrl_rdata = 32'(irq_enable_reg);
            6'h10:   ctrl_rdata = {31'h0, timeout_flag_reg};
            default: ctrl_rdata = 32'h0;
        endcase
        if (reg_off[5] && (reg_off[1:0] == 2'b00)) begin
            for (int p = 0; p < NUM_GPIO; p++) begin
                if (reg_off[4:2] == 3'(p)) ctrl_rdata = 32'(func_sel[p]);
            end
        end
    end

    // Ready/data of whichever slot the address points at
    logic        sel_ready;
    logic [31:0] sel_data;
    always_comb begin
        sel_ready = 1'b0;
        sel_data  = 32'h0;
        if (addr_in[10]) begin
            sel_ready = 1'b1;
            for (int s = 0; s < NUM_SIMPLE; s++) begin
                if (addr_in[7:4] == 4'(s)) sel_data = {24'h0, simple_data_arr[s]};
            end
        end else if (ctrl_sel) begin
            sel_ready = 1'b1;
            sel_data  = ctrl_rdata;
        end else begin
            for (int s = 2; s < NUM_USER; s++) begin
                if (addr_in[9:6] == 4'(s)) begin
                    sel_ready = user_ready[s];
                    sel_data  = user_data_arr[s];
                end
            end
        end
    end

    // Read capture/hold, timeout counter and sticky timeout flag
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_reg     <= 32'h0;
            hold_reg         <= 1'b0;
            wait_cnt_reg     <= '0;
            timeout_flag_reg <= 1'b0;
        end else begin
            if (ctrl_wr && (reg_off == 6'h10) && data_in[0]) timeout_flag_reg <= 1'b0;
            if (!read_req) begin
                hold_reg     <= 1'b0;
                wait_cnt_reg <= '0;
            end else if (data_read_complete) begin
                // Release wins over a coinciding capture; it is retried next cycle
                hold_reg <= 1'b0;
            end else if (!hold_reg) begin
                if (sel_ready) begin
                    data_out_reg <= sel_data;
                    hold_reg     <= 1'b1;
                    wait_cnt_reg <= '0;
                end else if ((TIMEOUT_CYCLES != 0) && (wait_cnt_reg == TMO_LAST)) begin
                    data_out_reg     <= TIMEOUT_DATA;
                    hold_reg         <= 1'b1;
                    wait_cnt_reg     <= '0;
                    timeout_flag_reg <= 1'b1;
                end else if (TIMEOUT_CYCLES != 0) begin
                    wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
                end
            end
        end
    end

    assign data_out   = data_out_reg;
    assign data_ready = (hold_reg && read_req) || write_req;

    // GPIO output register
    always_ff @(posedge clk) begin
        if (rst) begin
            gpio_out_reg <= '0;
        end else if (ctrl_wr && (reg_off == 6'h00)) begin
            gpio_out_reg <= data_in[NUM_GPIO-1:0];
        end
    end

    // Interrupt edge capture; a new edge beats a same-cycle write-1-clear
    logic [NUM_USER-1:0] irq_set;
    logic [NUM_USER-1:0] irq_clr;
    assign irq_set = user_irq & ~irq_prev_reg & IRQ_MASK;
    assign irq_clr = (ctrl_wr && (reg_off == 6'h08)) ? data_in[NUM_USER-1:0] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_prev_reg    <= '0;
            irq_pending_reg <= '0;
            irq_enable_reg  <= '0;
        end else begin
            irq_prev_reg    <= user_irq;
            irq_pending_reg <= (irq_pending_reg & ~irq_clr) | irq_set;
            if (ctrl_wr && (reg_off == 6'h0C)) irq_enable_reg <= data_in[NUM_USER-1:0];
        end
    end

    assign irq_out = irq_pending_reg & irq_enable_reg;

    // Per-pin function select register and output mux
    generate
        for (genvar gi = 0; gi < NUM_GPIO; gi++) begin : g_pin
            localparam logic [4:0] FS_RST = (gi == 0) ? 5'd2 : (gi == 1) ? 5'd3 : 5'd1;
            logic [4:0] fs_reg;
            logic       pin_val;

            // func_sel[gi] register; pins 0/1 default to the UART
            always_ff @(posedge clk) begin
                if (rst) begin
                    fs_reg <= FS_RST;
                end else if (ctrl_wr && (reg_off == 6'(32 + 4*gi))) begin
                    fs_reg <= data_in[4:0];
                end
            end

            // Pick bit gi of the chosen slot's uo; user slot 1 supplies gpio_out
            always_comb begin
                pin_val = 1'b0;
                if (fs_reg[4]) begin
                    for (int s = 0; s < NUM_SIMPLE; s++) begin
                        if (fs_reg[3:0] == 4'(s)) pin_val = simple_uo_arr[s][gi];
                    end
                end else begin
                    for (int s = 0; s < NUM_USER; s++) begin
                        if (fs_reg[3:0] == 4'(s)) pin_val = (s == 1) ? gpio_out_reg[gi] : user_uo_arr[s][gi];
                    end
                end
            end

            assign func_sel[gi] = fs_reg;
            assign pin_next[gi] = pin_val;
        end
    endgenerate

    // Registered pad outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            uo_out_reg <= '0;
        end else begin
            uo_out_reg <= pin_next;
        end
    end

    assign uo_out = uo_out_reg;

endmodule

// File: tb/tb_tinyqv_peri_fabric.sv
// Randomised bench for tinyqv_peri_fabric with a transaction-level reference model.
module tb_tinyqv_peri_fabric;

    localparam int NU  = 16;
    localparam int NS  = 16;
    localparam int NG  = 8;
    localparam int TMO = 4;

    logic            clk;
    logic            rst;
    logic [10:0]     addr_in;
    logic [31:0]     data_in;
    logic [1:0]      data_write_n;
    logic [1:0]      data_read_n;
    logic            data_read_complete;
    logic [31:0]     data_out;
    logic            data_ready;
    logic [NU-1:0]   user_sel;
    logic [NS-1:0]   simple_sel;
    logic [32*NU-1:0] user_data;
    logic [NU-1:0]   user_ready;
    logic [NU-1:0]   user_irq;
    logic [8*NS-1:0] simple_data;
    logic [8*NU-1:0] user_uo;
    logic [8*NS-1:0] simple_uo;
    logic [NG-1:0]   ui_in;
    logic [NG-1:0]   uo_out;
    logic [NU-1:0]   irq_out;

    tinyqv_peri_fabric #(
        .NUM_USER(NU), .NUM_SIMPLE(NS), .NUM_GPIO(NG),
        .TIMEOUT_CYCLES(TMO), .TIMEOUT_DATA(32'hFFFF_FFFF)
    ) dut (
        .clk(clk), .rst(rst), .addr_in(addr_in), .data_in(data_in),
        .data_write_n(data_write_n), .data_read_n(data_read_n),
        .data_read_complete(data_read_complete), .data_out(data_out),
        .data_ready(data_ready), .user_sel(user_sel), .simple_sel(simple_sel),
        .user_data(user_data), .user_ready(user_ready), .user_irq(user_irq),
        .simple_data(simple_data), .user_uo(user_uo), .simple_uo(simple_uo),
        .ui_in(ui_in), .uo_out(uo_out), .irq_out(irq_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model of the control register file
    logic [7:0]  m_gpio;
    logic [15:0] m_en;
    logic [15:0] m_pend;
    logic        m_tmo;
    logic [4:0]  m_fs [NG];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_gpio = 8'h0;
        m_en   = 16'h0;
        m_pend = 16'h0;
        m_tmo  = 1'b0;
        for (int p = 0; p < NG; p++) m_fs[p] = (p == 0) ? 5'd2 : (p == 1) ? 5'd3 : 5'd1;
    endtask

    function automatic logic [31:0] m_ctrl(input logic [5:0] off);
        logic [31:0] r;
        r = 32'h0;
        case (off)
            6'h00: r = {24'h0, m_gpio};
            6'h04: r = {24'h0, ui_in};
            6'h08: r = {16'h0, m_pend};
            6'h0C: r = {16'h0, m_en};
            6'h10: r = {31'h0, m_tmo};
            default: if (off[5] && off[1:0] == 2'b00) r = {27'h0, m_fs[off[4:2]]};
        endcase
        return r;
    endfunction

    function automatic logic [NG-1:0] m_uo();
        logic [NG-1:0] v;
        int s;
        for (int p = 0; p < NG; p++) begin
            s = int'(m_fs[p][3:0]);
            if (m_fs[p][4])  v[p] = (s < NS) ? simple_uo[8*s+p] : 1'b0;
            else if (s == 1) v[p] = m_gpio[p];
            else             v[p] = (s < NU) ? user_uo[8*s+p] : 1'b0;
        end
        return v;
    endfunction

    task automatic do_write(input logic [10:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        addr_in = a; data_in = d; data_write_n = 2'($urandom_range(0, 2));
        @(negedge clk);
        chk("wr_ack", {31'h0, data_ready}, 32'h1);
        @(posedge clk); #1;
        data_write_n = 2'b11;
        if (!a[10] && a[9:6] == 4'd1) begin
            case (a[5:0])
                6'h00: m_gpio = d[7:0];
                6'h08: m_pend = m_pend & ~d[15:0];
                6'h0C: m_en   = d[15:0];
                6'h10: if (d[0]) m_tmo = 1'b0;
                default: if (a[5] && a[1:0] == 2'b00) m_fs[a[4:2]] = d[4:0];
            endcase
        end
        $display("wr addr=%h data=%h", a, d);
    endtask

    // rdy_slot >= 0: that user slot's ready rises dly cycles after the request
    task automatic do_read(input logic [10:0] a, input int rdy_slot, input int dly,
                           input logic [31:0] exp_d, input int exp_lat, input string tag);
        int lat;
        lat = 0;
        @(posedge clk); #1;
        addr_in = a;
        data_read_n = 2'($urandom_range(0, 2));
        user_ready = NU'($urandom);
        if (rdy_slot >= 0) user_ready[rdy_slot] = (dly == 0);
        while (1) begin
            @(negedge clk);
            if (data_ready || lat >= 20) break;
            @(posedge clk); #1;
            lat++;
            if (rdy_slot >= 0) user_ready[rdy_slot] = (lat >= dly);
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_data"}, data_out, exp_d);
        @(posedge clk); #1;
        data_read_complete = 1'b1;
        @(negedge clk);
        chk({tag, "_held"}, {31'h0, data_ready}, 32'h1);
        @(posedge clk); #1;
        data_read_complete = 1'b0;
        @(negedge clk);
        chk({tag, "_released"}, {31'h0, data_ready}, 32'h0);
        @(posedge clk); #1;
        data_read_n = 2'b11;
        user_ready  = '0;
        $display("rd addr=%h data=%h lat=%0d", a, data_out, lat);
    endtask

    task automatic chk_gpio();
        @(posedge clk); #1;
        user_uo   = {$urandom, $urandom, $urandom, $urandom};
        simple_uo = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1;
        @(negedge clk);
        chk("uo_out", 32'(uo_out), 32'(m_uo()));
        $display("gpio fs3=%h uo_out=%h", m_fs[3], uo_out);
    endtask

    task automatic randomize_slots();
        ui_in = NG'($urandom);
        for (int s = 0; s < NU; s++) user_data[32*s +: 32] = $urandom;
        for (int s = 0; s < NS; s++) simple_data[8*s +: 8] = 8'($urandom);
    endtask

    initial begin
        int kind, s, d, off, w, p;
        logic [31:0] exp;
        rst = 1'b1; addr_in = '0; data_in = '0; data_write_n = 2'b11; data_read_n = 2'b11;
        data_read_complete = 1'b0; user_data = '0; user_ready = '0; user_irq = '0;
        simple_data = '0; user_uo = '0; simple_uo = '0; ui_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_data_out", data_out, 32'h0);
        chk("rst_ready", {31'h0, data_ready}, 32'h0);
        chk("rst_uo", 32'(uo_out), 32'h0);
        chk("rst_irq", 32'(irq_out), 32'h0);

        // ui_in read through slot 1
        ui_in = 8'hA5;
        do_read(11'h044, -1, 0, 32'h0000_00A5, 1, "ui_read");

        // Reserved slot 0 times out
        do_read(11'h000, -1, 0, 32'hFFFF_FFFF, TMO, "slot0_tmo");
        m_tmo = 1'b1;
        do_read(11'h050, -1, 0, 32'h1, 1, "status_set");
        do_write(11'h050, 32'h1);
        do_read(11'h050, -1, 0, 32'h0, 1, "status_clr");

        // Slow user slot 5
        user_data[32*5 +: 32] = 32'h1234_5678;
        do_read(11'h140, 5, 3, 32'h1234_5678, 4, "slot5_slow");
        do_read(11'h050, -1, 0, 32'h0, 1, "status_none");

        // Randomised traffic
        for (int i = 0; i < 60; i++) begin
            randomize_slots();
            kind = $urandom_range(0, 5);
            case (kind)
                0: begin
                    s = $urandom_range(0, NS - 1);
                    exp = {24'h0, simple_data[8*s +: 8]};
                    do_read(11'(32'h400 | (s << 4) | ($urandom & 32'h30F)), -1, 0, exp, 1, "rd_simple");
                end
                1: begin
                    s = $urandom_range(2, NU - 1);
                    d = $urandom_range(0, 6);
                    exp = (d < TMO) ? user_data[32*s +: 32] : 32'hFFFF_FFFF;
                    do_read(11'((s << 6) | ($urandom & 32'h3F)), s, d, exp,
                            (d < TMO) ? d + 1 : TMO, "rd_user");
                    if (d >= TMO) m_tmo = 1'b1;
                end
                2: begin
                    off = 4 * $urandom_range(0, 15);
                    do_read(11'(32'h040 | off), -1, 0, m_ctrl(6'(off)), 1, "rd_ctrl");
                end
                3: begin
                    w = $urandom_range(0, 4);
                    case (w)
                        0: do_write(11'h040, $urandom);
                        1: do_write(11'h04C, $urandom);
                        2: begin
                            p = $urandom_range(0, NG - 1);
                            do_write(11'(32'h060 + 4 * p), $urandom);
                        end
                        3: do_write(11'(32'h054 + 4 * $urandom_range(0, 2)), $urandom);
                        default: do_write(11'h050, 32'h1);
                    endcase
                    chk_gpio();
                end
                4: begin
                    do_read(11'($urandom & 32'h3F), -1, 0, 32'hFFFF_FFFF, TMO, "rd_slot0");
                    m_tmo = 1'b1;
                end
                default: chk_gpio();
            endcase
        end

        // Interrupts: enable 0,1,4 only
        do_write(11'h04C, 32'h0000_0013);
        @(posedge clk); #1 user_irq = 16'h0013;
        @(posedge clk); #1 user_irq = 16'h0000;
        m_pend = 16'h0010;
        @(posedge clk);
        @(negedge clk);
        chk("irq_held", 32'(irq_out), 32'h0010);
        do_read(11'h048, -1, 0, 32'h0000_0010, 1, "irq_pend");
        // New edge coincides with write-1-clear
        @(posedge clk); #1;
        user_irq = 16'h0010; addr_in = 11'h048; data_in = 32'h10; data_write_n = 2'b10;
        @(negedge clk);
        chk("irq_w1c_ack", {31'h0, data_ready}, 32'h1);
        @(posedge clk); #1 data_write_n = 2'b11;
        @(negedge clk);
        chk("irq_set_wins", 32'(irq_out), 32'h0010);
        $display("irq set-wins irq_out=%h", irq_out);
        // Clear with level still high: no new edge
        do_write(11'h048, 32'h10);
        @(negedge clk);
        chk("irq_cleared", 32'(irq_out), 32'h0);
        // Disabled source latches but does not drive irq_out
        @(posedge clk); #1 user_irq = 16'h0030;
        m_pend = 16'h0020;
        @(posedge clk); #1 user_irq = 16'h0000;
        @(negedge clk);
        chk("irq_masked", 32'(irq_out), 32'h0);
        do_read(11'h048, -1, 0, 32'h0000_0020, 1, "irq_pend5");
        do_write(11'h048, 32'h20);
        do_read(11'h048, -1, 0, 32'h0, 1, "irq_pend_clr");

        // GPIO function select and 1-cycle output lag
        user_uo = '0; simple_uo = '0;
        simple_uo[8*2 +: 8] = 8'h08;
        do_write(11'h06C, 32'h01);
        do_write(11'h040, 32'h00);
        @(posedge clk);
        @(negedge clk);
        chk("pin3_gpio0", 32'(uo_out[3]), 32'h0);
        do_write(11'h06C, 32'h12);
        @(negedge clk);
        chk("pin3_lag_old", 32'(uo_out[3]), 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("pin3_simple2", 32'(uo_out[3]), 32'h1);
        chk("uo_full", 32'(uo_out), 32'(m_uo()));
        @(posedge clk); #1 simple_uo[8*2 +: 8] = 8'h00;
        @(negedge clk);
        chk("uo_lag_hold", 32'(uo_out[3]), 32'h1);
        @(posedge clk);
        @(negedge clk);
        chk("uo_lag_follow", 32'(uo_out[3]), 32'h0);
        do_write(11'h06C, 32'h01);
        @(posedge clk);
        @(negedge clk);
        chk("pin3_back_gpio", 32'(uo_out[3]), 32'h0);
        do_write(11'h040, 32'h08);
        @(posedge clk);
        @(negedge clk);
        chk("pin3_gpio1", 32'(uo_out[3]), 32'h1);

        // Reset during a held read
        @(posedge clk); #1 addr_in = 11'h044; data_read_n = 2'b10;
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre_rst_ready", {31'h0, data_ready}, 32'h1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", {31'h0, data_ready}, 32'h0);
        chk("post_rst_uo", 32'(uo_out), 32'h0);
        chk("post_rst_data", data_out, 32'h0);
        @(posedge clk); #1 data_read_n = 2'b11;
        model_reset();
        $display("reset during held read done");
        do_read(11'h060, -1, 0, 32'd2, 1, "fs0_rst");
        do_read(11'h064, -1, 0, 32'd3, 1, "fs1_rst");
        do_read(11'h068, -1, 0, 32'd1, 1, "fs2_rst");
        do_read(11'h06C, -1, 0, 32'd1, 1, "fs3_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
